// File: rtl/sfm_tcdm_pkg.sv
// sfm_tcdm_pkg
// Shared definitions for the softmax-streamer TCDM splitter: the lane
// width constants, lane data/byte-enable types and the lane address helper.
package sfm_tcdm_pkg;

    localparam int unsigned LANE_DW = 32;
    localparam int unsigned LANE_BE = LANE_DW / 8;

    typedef logic [LANE_DW-1:0] lane_data_t;
    typedef logic [LANE_BE-1:0] lane_be_t;

    // Byte address of lane ii within a wide word starting at base.
    function automatic logic [31:0] lane_addr(input logic [31:0] base, input int unsigned ii);
        return base + 32'(ii * LANE_BE);
    endfunction

endpackage

// File: rtl/sfm_lane_fifo.sv
// sfm_lane_fifo
// Per-lane read response FIFO, DEPTH x 32 bit. Output data comes straight
// from the storage registers, so a pushed word is visible the cycle after
// the push (no fall-through).
// Ports:
//   clk_i, rst_ni  clock, synchronous active-low reset
//   push_i/data_i  write side; a push into a full FIFO is dropped unless a
//                  pop happens in the same cycle
//   pop_i/data_o   read side; data_o is the head entry when !empty_o
//   full_o/empty_o occupancy flags
module sfm_lane_fifo
    import sfm_tcdm_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       push_i,
    input  lane_data_t data_i,
    input  logic       pop_i,
    output lane_data_t data_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    lane_data_t    mem_q [DEPTH];
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign data_o  = mem_q[rptr_q];

    // A pop frees the head slot before the push is considered.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        rptr_d = rptr_q;
        wptr_d = wptr_q;
        cnt_d  = cnt_q;
        if (do_pop)
            rptr_d = (rptr_q == AW'(DEPTH - 1)) ? '0 : rptr_q + 1'b1;
        if (do_push)
            wptr_d = (wptr_q == AW'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
        if (do_push && !do_pop)
            cnt_d = cnt_q + 1'b1;
        else if (do_pop && !do_push)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rptr_q <= '0;
            wptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            rptr_q <= rptr_d;
            wptr_q <= wptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push)
            mem_q[wptr_q] <= data_i;
    end

endmodule

// File: rtl/sfm_tcdm_splitter.sv
// sfm_tcdm_splitter
// Splits one wide TCDM request into MP 32-bit lane requests. Lanes may be
// granted in different cycles; the wide grant fires once every lane is
// granted (or skipped). Read responses per lane are queued and recombined
// into one wide response when every lane has data. Outstanding wide reads
// are bounded by DEPTH.
// Ports:
//   clk_i, rst_ni              clock, synchronous active-low reset
//   req_i/gnt_o                wide request handshake (gnt_o combinational)
//   add_i, wen_i, be_i, data_i wide request payload (wen_i=1 is a read)
//   r_data_o/r_valid_o/r_ready_i  wide read response
//   err_o                      sticky protocol error
//   tcdm_*                     MP lane ports towards the interconnect
module sfm_tcdm_splitter
    import sfm_tcdm_pkg::*;
#(
    parameter int unsigned DW         = 128,
    parameter int unsigned MP         = DW / LANE_DW,
    parameter int unsigned DEPTH      = 4,
    parameter bit          SKIP_EMPTY = 1'b1
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           req_i,
    output logic                           gnt_o,
    input  logic [31:0]                    add_i,
    input  logic                           wen_i,
    input  logic [DW/8-1:0]                be_i,
    input  logic [DW-1:0]                  data_i,
    output logic [DW-1:0]                  r_data_o,
    output logic                           r_valid_o,
    input  logic                           r_ready_i,
    output logic                           err_o,
    output logic [MP-1:0]                  tcdm_req_o,
    input  logic [MP-1:0]                  tcdm_gnt_i,
    output logic [MP-1:0][LANE_DW-1:0]     tcdm_add_o,
    output logic [MP-1:0]                  tcdm_wen_o,
    output logic [MP-1:0][LANE_BE-1:0]     tcdm_be_o,
    output logic [MP-1:0][LANE_DW-1:0]     tcdm_data_o,
    input  logic [MP-1:0][LANE_DW-1:0]     tcdm_r_data_i,
    input  logic [MP-1:0]                  tcdm_r_valid_i
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [MP-1:0]              done_q, done_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic                       err_q, err_d;
    logic [MP-1:0]              skip;
    logic [MP-1:0]              fifo_full, fifo_empty;
    logic [MP-1:0][LANE_DW-1:0] fifo_rdata;
    logic                       stall, active, pop, inc, dec;

    // Lane fan-out of the wide payload.
    always_comb begin
        for (int unsigned ii = 0; ii < MP; ii++) begin
            skip[ii]        = SKIP_EMPTY & ~wen_i & (be_i[ii*LANE_BE +: LANE_BE] == '0);
            tcdm_add_o[ii]  = lane_addr(add_i, ii);
            tcdm_wen_o[ii]  = wen_i;
            tcdm_be_o[ii]   = be_i[ii*LANE_BE +: LANE_BE];
            tcdm_data_o[ii] = data_i[ii*LANE_DW +: LANE_DW];
            r_data_o[ii*LANE_DW +: LANE_DW] = fifo_rdata[ii];
        end
    end

    // Requests are gated by rst_ni so nothing leaks out during reset.
    assign stall      = wen_i & (cnt_q == CW'(DEPTH));
    assign active     = rst_ni & req_i & ~stall;
    assign tcdm_req_o = {MP{active}} & ~done_q & ~skip;
    assign gnt_o      = active & (&(done_q | tcdm_gnt_i | skip));

    assign r_valid_o  = &(~fifo_empty);
    assign pop        = r_valid_o & r_ready_i;
    assign inc        = gnt_o & wen_i;
    // Underflow guard: only reachable after stray responses have raised err.
    assign dec        = pop & (cnt_q != '0);

    always_comb begin
        done_d = gnt_o ? '0 : (done_q | (tcdm_req_o & tcdm_gnt_i));
        cnt_d  = cnt_q;
        if (inc && !dec)
            cnt_d = cnt_q + 1'b1;
        else if (dec && !inc)
            cnt_d = cnt_q - 1'b1;
        err_d = err_q
              | (|(tcdm_r_valid_i & fifo_full & ~{MP{pop}}))
              | ((cnt_q == '0) & (|tcdm_r_valid_i));
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            done_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            done_q <= done_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    assign err_o = err_q;

    for (genvar g = 0; g < MP; g++) begin : gen_lane
        sfm_lane_fifo #(
            .DEPTH (DEPTH)
        ) i_fifo (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .push_i  (tcdm_r_valid_i[g]),
            .data_i  (tcdm_r_data_i[g]),
            .pop_i   (pop),
            .data_o  (fifo_rdata[g]),
            .full_o  (fifo_full[g]),
            .empty_o (fifo_empty[g])
        );
    end

endmodule
